// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states and flush-length range.
// No logic of its own; used at elaboration by pipe_hazard_ctrl.
// Optional perf counters in the top are enabled by PIPE_HAZARD_PERF_CNT_EN.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      FLUSH      = 2'd2,
      MEM_WAIT   = 2'd3
   } state_e;

   localparam int FLUSH_CYCLES_MIN = 1;
   localparam int FLUSH_CYCLES_MAX = 3;
   localparam int FLUSH_CNT_W      = 2;

   // Counter value loaded on a taken branch; out-of-range requests are clamped
   // so the counter can never be loaded with a value it cannot hold.
   function automatic logic [FLUSH_CNT_W-1:0] flush_reload(input int cycles);
      int c;
      c = cycles;
      if (c < FLUSH_CYCLES_MIN) c = FLUSH_CYCLES_MIN;
      if (c > FLUSH_CYCLES_MAX) c = FLUSH_CYCLES_MAX;
      return FLUSH_CNT_W'(c - 1);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: ID/EX load destination vs IF/ID source registers.
// Purely combinational, zero-cycle latency.
// No backpressure; the hit is consumed by the hazard FSM.
module load_use_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_ex_memread,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   output logic                  hit
);

   // Register 0 is hardwired, so a load targeting it can never create a dependency.
   always_comb begin
      hit = id_ex_memread && (id_ex_rd != '0) &&
            ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait.
// Outputs are combinational from state and inputs (zero-cycle latency).
// dmem_ready=0 freezes the whole pipe; PIPE_HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  id_ex_memread,
   input  logic [REG_ADDR_W-1:0] id_ex_rd,
   input  logic [REG_ADDR_W-1:0] if_id_rs1,
   input  logic [REG_ADDR_W-1:0] if_id_rs2,
   input  logic                  branch_taken,
   input  logic                  dmem_ready,
   output logic                  pc_en,
   output logic                  if_id_hazard,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  pipe_en
`ifdef PIPE_HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   localparam logic [FLUSH_CNT_W-1:0] RELOAD = flush_reload(FLUSH_CYCLES);

   state_e                 state_q, state_d;
   logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   logic                   lu_hit;

   load_use_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_lud (
      .id_ex_memread(id_ex_memread),
      .id_ex_rd     (id_ex_rd),
      .if_id_rs1    (if_id_rs1),
      .if_id_rs2    (if_id_rs2),
      .hit          (lu_hit)
   );

   // State and remaining-flush counter; reset abandons any flush or memory wait.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and control outputs; memory wait beats branch beats load-use.
   always_comb begin
      pc_en        = 1'b1;
      pipe_en      = 1'b1;
      if_id_hazard = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = state_q;
      cnt_d        = cnt_q;

      if (!dmem_ready) begin
         // Whole pipe frozen; flush counter keeps its value so a flush resumes afterwards.
         pc_en        = 1'b0;
         pipe_en      = 1'b0;
         if_id_hazard = 1'b1;
         state_d      = MEM_WAIT;
      end else if (branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         cnt_d        = RELOAD;
         state_d      = (RELOAD != '0) ? FLUSH : RUN;
      end else begin
         case (state_q)
            FLUSH: begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               cnt_d        = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
               state_d      = (cnt_q <= 1) ? RUN : FLUSH;
            end
            MEM_WAIT: begin
               // A non-zero counter means the wait interrupted a flush: finish it first.
               if (cnt_q != '0) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  cnt_d        = cnt_q - 1'b1;
                  state_d      = (cnt_q == 1) ? RUN : FLUSH;
               end else if (lu_hit) begin
                  pc_en        = 1'b0;
                  if_id_hazard = 1'b1;
                  id_ex_bubble = 1'b1;
                  state_d      = LOAD_STALL;
               end else begin
                  state_d = RUN;
               end
            end
            LOAD_STALL: begin
               // The stalled load has advanced; the comparator still sees stale
               // operands this cycle, so it is deliberately ignored.
               state_d = RUN;
            end
            default: begin
               if (lu_hit) begin
                  pc_en        = 1'b0;
                  if_id_hazard = 1'b1;
                  id_ex_bubble = 1'b1;
                  state_d      = LOAD_STALL;
               end
            end
         endcase
      end

      if (arst) begin
         pc_en        = 1'b0;
         pipe_en      = 1'b0;
         if_id_hazard = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_bubble = 1'b0;
      end
   end

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Free-running event counters; both wrap naturally at 2^32.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_en)      stall_cnt_q <= stall_cnt_q + 32'd1;
         if (if_id_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl with FLUSH_CYCLES=3: directed per-cycle vectors.
// Expected outputs are queued at stimulus time and compared by a monitor at negedge.
// Summary line reports passed/total checks.
module tb_pipe_hazard_ctrl;

   localparam int AW = 5;

   // Expected output vector order: {pc_en, pipe_en, if_id_hazard, if_id_flush, id_ex_bubble}
   localparam logic [4:0] O_RST   = 5'b00000;
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_STALL = 5'b01101;
   localparam logic [4:0] O_FLUSH = 5'b11011;
   localparam logic [4:0] O_WAIT  = 5'b00100;

   typedef struct {
      logic [4:0] v;
      string      nm;
   } exp_t;

   logic          clk;
   logic          arst;
   logic          id_ex_memread;
   logic [AW-1:0] id_ex_rd;
   logic [AW-1:0] if_id_rs1;
   logic [AW-1:0] if_id_rs2;
   logic          branch_taken;
   logic          dmem_ready;
   logic          pc_en;
   logic          if_id_hazard;
   logic          if_id_flush;
   logic          id_ex_bubble;
   logic          pipe_en;
`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   flush_cnt;
`endif

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   pipe_hazard_ctrl #(
      .REG_ADDR_W  (AW),
      .FLUSH_CYCLES(3)
   ) dut (
      .clk          (clk),
      .arst         (arst),
      .id_ex_memread(id_ex_memread),
      .id_ex_rd     (id_ex_rd),
      .if_id_rs1    (if_id_rs1),
      .if_id_rs2    (if_id_rs2),
      .branch_taken (branch_taken),
      .dmem_ready   (dmem_ready),
      .pc_en        (pc_en),
      .if_id_hazard (if_id_hazard),
      .if_id_flush  (if_id_flush),
      .id_ex_bubble (id_ex_bubble),
      .pipe_en      (pipe_en)
`ifdef PIPE_HAZARD_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
   task automatic step(input logic a, input logic mr, input logic [AW-1:0] rd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic br, input logic dm, input logic [4:0] ev, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      arst          = a;
      id_ex_memread = mr;
      id_ex_rd      = rd;
      if_id_rs1     = r1;
      if_id_rs2     = r2;
      branch_taken  = br;
      dmem_ready    = dm;
      e.v  = ev;
      e.nm = nm;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [4:0] ev, input string nm);
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, ev, nm);
   endtask

   // Monitor: compare every queued expectation against the settled outputs.
   initial begin
      exp_t       e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_en, pipe_en, if_id_hazard, if_id_flush, id_ex_bubble};
            n_chk++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s: got pc/pipe/haz/flush/bub=%b expected %b", e.nm, act, e.v);
            n_chk++;
            if (!(if_id_flush && if_id_hazard)) n_pass++;
            else $display("FAIL %s_excl: flush and hazard both high, got %b%b expected not 11",
                          e.nm, if_id_flush, if_id_hazard);
`ifdef PIPE_HAZARD_PERF_CNT_EN
            if (arst) begin
               n_chk++;
               if (stall_cnt == 32'd0 && flush_cnt == 32'd0) n_pass++;
               else $display("FAIL %s_cnt: stall_cnt=%0d flush_cnt=%0d expected 0/0",
                             e.nm, stall_cnt, flush_cnt);
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      arst          = 1'b1;
      id_ex_memread = 1'b0;
      id_ex_rd      = '0;
      if_id_rs1     = '0;
      if_id_rs2     = '0;
      branch_taken  = 1'b0;
      dmem_ready    = 1'b1;

      // Reset state, then plain RUN
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, O_RST, "rst0");
      step(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, O_RST, "rst_busy_inputs");
      idle(O_RUN, "run_idle");

      // Load-use on rs2: one stall cycle, not re-detected in LOAD_STALL
      step(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, O_STALL, "lu_rs2");
      step(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, O_RUN, "lu_once");
      idle(O_RUN, "lu_after");

      // No hazard: rd=0, or no load
      step(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, O_RUN, "rd0_nostall");
      step(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, O_RUN, "noload_nostall");

      // Load-use on rs1
      step(1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b1, O_STALL, "lu_rs1");
      idle(O_RUN, "lu_rs1_after");

      // Branch: exactly three flush cycles
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, O_FLUSH, "br_c0");
      idle(O_FLUSH, "br_c1");
      idle(O_FLUSH, "br_c2");
      idle(O_RUN, "br_done");

      // Branch together with load-use: flush only
      step(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, O_FLUSH, "br_lu_c0");
      idle(O_FLUSH, "br_lu_c1");
      idle(O_FLUSH, "br_lu_c2");
      idle(O_RUN, "br_lu_done");

      // Memory wait for 4 cycles in the middle of a flush
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, O_FLUSH, "fw_br");
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_WAIT, "fw_wait");
      idle(O_FLUSH, "fw_resume1");
      idle(O_FLUSH, "fw_resume2");
      idle(O_RUN, "fw_done");

      // Memory wait beats branch; branch acts once memory completes
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, O_WAIT, "dm_over_br");
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, O_FLUSH, "wait_exit_br");
      idle(O_FLUSH, "wait_exit_br1");
      idle(O_FLUSH, "wait_exit_br2");
      idle(O_RUN, "wait_exit_br_done");

      // Load-use detected on leaving memory wait
      step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, O_WAIT, "dm_over_lu");
      step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, O_STALL, "wait_exit_lu");
      idle(O_RUN, "wait_exit_lu_done");

      // Reset in the middle of a flush
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, O_FLUSH, "rf_br");
      idle(O_FLUSH, "rf_c1");
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, O_RST, "rf_reset0");
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, O_RST, "rf_reset1");
      idle(O_RUN, "rf_release");
      idle(O_RUN, "rf_release2");

      // Reset in the middle of a memory wait
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_WAIT, "rw_wait");
      step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, O_RST, "rw_reset");
      idle(O_RUN, "rw_release");

      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
